out_vc_ts_sched: RTL and testbench

- Per-output-port scheduler for the timestamped NoC simulator.
- Each cycle it examines the nVCs flits waiting at an output interface and picks the oldest flit whose timestamp is not in the future relative to sim_time.
- It issues a one-hot VC grant to the output datapath under a valid/ready handshake.
- It reports to the global time controller, through `ready`, when the port has no eligible work, so simulation time may advance.

---
 rtl/out_vc_ts_sched_pkg.sv | 17 +
 rtl/out_vc_ts_sched_ts_min_select.sv | 41 ++++
 rtl/out_vc_ts_sched.sv | 137 +++++++++++++
 tb/tb_out_vc_ts_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/out_vc_ts_sched_pkg.sv
// rtl/out_vc_ts_sched_pkg.sv - shared timestamp width and scheduler state encoding
package out_vc_ts_sched_pkg;

    localparam int TS_WIDTH = 16;

    // Fixed encoding so external monitors can decode the scheduler state.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        GRANT  = ST_GRANT,
        SETTLE = ST_SETTLE
    } state_t;

endpackage

// File: rtl/out_vc_ts_sched_ts_min_select.sv
// rtl/out_vc_ts_sched_ts_min_select.sv - oldest-eligible VC picker with round-robin tie break
module ts_min_select
    import out_vc_ts_sched_pkg::*;
#(
    parameter int nVCs = 2,
    localparam int PW  = $clog2(nVCs)
) (
    input  logic [nVCs-1:0]          i_elig,
    input  logic [nVCs*TS_WIDTH-1:0] i_ts,
    input  logic [PW-1:0]            i_rr_ptr,
    output logic [nVCs-1:0]          o_winner,
    output logic                     o_any_elig
);

    logic [TS_WIDTH-1:0] w_best;
    logic                w_found;
    int                  w_sel;
    int                  w_k;

    // Scan starting at rr_ptr; strict less-than keeps the first tied VC in that order.
    always_comb begin
        w_found  = 1'b0;
        w_best   = '0;
        w_sel    = 0;
        w_k      = 0;
        o_winner = '0;
        for (int j = 0; j < nVCs; j++) begin
            w_k = int'(i_rr_ptr) + j;
            if (w_k >= nVCs) w_k = w_k - nVCs;
            if (i_elig[w_k] && (!w_found || (i_ts[w_k*TS_WIDTH +: TS_WIDTH] < w_best))) begin
                w_found = 1'b1;
                w_best  = i_ts[w_k*TS_WIDTH +: TS_WIDTH];
                w_sel   = w_k;
            end
        end
        if (w_found) o_winner[w_sel] = 1'b1;
    end

    assign o_any_elig = |i_elig;

endmodule

// File: rtl/out_vc_ts_sched.sv
// rtl/out_vc_ts_sched.sv - per-output-port timestamp scheduler with valid/ready grant
// Optional counters flits_sent/withdraw_cnt under OUT_VC_SCHED_STATS_EN.
module out_vc_ts_sched
    import out_vc_ts_sched_pkg::*;
#(
    parameter int nVCs = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [nVCs*TS_WIDTH-1:0] flit_ts,
    input  logic [nVCs-1:0]          flit_valid,
    input  logic [TS_WIDTH-1:0]      sim_time,
    output logic [nVCs-1:0]          grant,
    output logic                     grant_valid,
    input  logic                     out_ready,
    output logic                     ready
`ifdef OUT_VC_SCHED_STATS_EN
    ,
    output logic [31:0]              flits_sent,
    output logic [15:0]              withdraw_cnt
`endif
);

    localparam int PW = $clog2(nVCs);

    state_t          r_state, w_state_nxt;
    logic [nVCs-1:0] r_grant, w_grant_nxt;
    logic            r_gv, w_gv_nxt;
    logic            r_ready, w_ready_nxt;
    logic [PW-1:0]   r_rr, w_rr_nxt;
    logic [nVCs-1:0] w_elig, w_winner;
    logic            w_any_elig;
    logic [PW-1:0]   w_gidx;
    logic            w_xfer, w_wdraw;

    always_comb begin
        for (int i = 0; i < nVCs; i++)
            w_elig[i] = flit_valid[i] && (flit_ts[i*TS_WIDTH +: TS_WIDTH] <= sim_time);
    end

    ts_min_select #(.nVCs(nVCs)) u_sel (
        .i_elig     (w_elig),
        .i_ts       (flit_ts),
        .i_rr_ptr   (r_rr),
        .o_winner   (w_winner),
        .o_any_elig (w_any_elig)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < nVCs; i++)
            if (r_grant[i]) w_gidx = PW'(i);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gv_nxt    = r_gv;
        w_rr_nxt    = r_rr;
        w_xfer      = 1'b0;
        w_wdraw     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_elig) begin
                    w_grant_nxt = w_winner;
                    w_gv_nxt    = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A completed transfer takes priority over a same-cycle withdrawal.
                if (out_ready) begin
                    w_xfer      = 1'b1;
                    w_rr_nxt    = (w_gidx == PW'(nVCs-1)) ? '0 : w_gidx + PW'(1);
                    w_grant_nxt = '0;
                    w_gv_nxt    = 1'b0;
                    w_state_nxt = SETTLE;
                end else if (!(|(r_grant & flit_valid))) begin
                    w_wdraw     = 1'b1;
                    w_grant_nxt = '0;
                    w_gv_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            SETTLE: begin
                w_grant_nxt = '0;
                w_gv_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_gv_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == IDLE) && !w_any_elig && (r_state != SETTLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gv    <= 1'b0;
            r_ready <= 1'b0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gv    <= w_gv_nxt;
            r_ready <= w_ready_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_gv;
    assign ready       = r_ready;

`ifdef OUT_VC_SCHED_STATS_EN
    logic [31:0] r_flits_sent;
    logic [15:0] r_withdraw_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flits_sent   <= '0;
            r_withdraw_cnt <= '0;
        end else begin
            if (w_xfer && (r_flits_sent != '1))    r_flits_sent   <= r_flits_sent + 32'd1;
            if (w_wdraw && (r_withdraw_cnt != '1)) r_withdraw_cnt <= r_withdraw_cnt + 16'd1;
        end
    end

    assign flits_sent   = r_flits_sent;
    assign withdraw_cnt = r_withdraw_cnt;
`endif

endmodule

// File: tb/tb_out_vc_ts_sched.sv
// tb/tb_out_vc_ts_sched.sv - directed self-checking bench for out_vc_ts_sched (nVCs=2)
module tb_out_vc_ts_sched;
    import out_vc_ts_sched_pkg::*;

    logic                  clock;
    logic                  reset;
    logic [2*TS_WIDTH-1:0] flit_ts;
    logic [1:0]            flit_valid;
    logic [TS_WIDTH-1:0]   sim_time;
    logic [1:0]            grant;
    logic                  grant_valid;
    logic                  out_ready;
    logic                  ready;
`ifdef OUT_VC_SCHED_STATS_EN
    logic [31:0]           flits_sent;
    logic [15:0]           withdraw_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    out_vc_ts_sched #(.nVCs(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .flit_ts     (flit_ts),
        .flit_valid  (flit_valid),
        .sim_time    (sim_time),
        .grant       (grant),
        .grant_valid (grant_valid),
        .out_ready   (out_ready),
        .ready       (ready)
`ifdef OUT_VC_SCHED_STATS_EN
        ,
        .flits_sent  (flits_sent),
        .withdraw_cnt(withdraw_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int ts0, input int ts1, input int st, input logic ordy);
        flit_valid = v;
        flit_ts    = {TS_WIDTH'(ts1), TS_WIDTH'(ts0)};
        sim_time   = TS_WIDTH'(st);
        out_ready  = ordy;
    endtask

    task automatic check_out(input string tag, input int g, input int gv);
        check({tag, "_grant"}, 32'(grant), g);
        check({tag, "_gv"}, 32'(grant_valid), gv);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(2'b00, 0, 0, 0, 1'b0);
        #2;
        check_out("rst", 0, 0);
        check("rst_ready", 32'(ready), 0);
        do_reset();
        tick();
        check("rel_ready", 32'(ready), 1);

        // 1: oldest eligible timestamp wins
        drive(2'b11, 8, 5, 10, 1'b0);
        check("t1_pre_gv", 32'(grant_valid), 0);
        tick();
        check_out("t1_g1", 2, 1);
        check("t1_ready", 32'(ready), 0);
        out_ready = 1'b1;
        tick();
        check_out("t1_settle", 0, 0);
        drive(2'b01, 8, 5, 10, 1'b0);
        tick();
        check_out("t1_idle", 0, 0);
        tick();
        check_out("t1_g2", 1, 1);
        out_ready = 1'b1;
        tick();
        drive(2'b00, 0, 0, 10, 1'b0);
        tick();
        check("t1_ready_settle", 32'(ready), 0);
        tick();
        check("t1_ready_idle", 32'(ready), 1);

        // 2: future flit waits for sim_time
        drive(2'b01, 7, 0, 4, 1'b0);
        tick();
        check_out("t2_future", 0, 0);
        check("t2_ready", 32'(ready), 1);
        sim_time = 16'd7;
        tick();
        check_out("t2_g", 1, 1);
        check("t2_ready", 32'(ready), 0);

        // 3: ties alternate from rr_ptr=0
        drive(2'b00, 0, 0, 0, 1'b0);
        do_reset();
        drive(2'b11, 3, 3, 3, 1'b1);
        tick();
        check_out("t3_a", 1, 1);
        tick();
        check_out("t3_a_settle", 0, 0);
        tick();
        check_out("t3_a_idle", 0, 0);
        tick();
        check_out("t3_b", 2, 1);
        tick();
        tick();
        tick();
        check_out("t3_c", 1, 1);
        tick();
        drive(2'b00, 0, 0, 3, 1'b0);
        tick();

        // 4: grant held under backpressure; rr_ptr is 1 here
        drive(2'b01, 5, 0, 10, 1'b0);
        tick();
        check_out("t4_g", 1, 1);
        drive(2'b11, 5, 2, 10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("t4_hold%0d", i), 1, 1);
            sim_time = sim_time + 16'd1;
        end
        out_ready = 1'b1;
        tick();
        check_out("t4_settle", 0, 0);
        drive(2'b10, 0, 2, 15, 1'b0);
        tick();
        tick();
        check_out("t4_vc1", 2, 1);
        out_ready = 1'b1;
        tick();
        drive(2'b00, 0, 0, 15, 1'b0);
        tick();

        // 5: withdrawal keeps rr_ptr at 0, then transfer beats withdrawal
        drive(2'b01, 5, 0, 10, 1'b0);
        tick();
        check_out("t5_g", 1, 1);
        flit_valid = 2'b00;
        tick();
        check_out("t5_wd", 0, 0);
        check("t5_wd_ready", 32'(ready), 1);
`ifdef OUT_VC_SCHED_STATS_EN
        check("t5_wd_cnt", 32'(withdraw_cnt), 1);
`endif
        drive(2'b11, 3, 3, 10, 1'b0);
        tick();
        check_out("t5_rr_kept", 1, 1);
        drive(2'b10, 3, 3, 10, 1'b1);
        tick();
        check_out("t5_sim_settle", 0, 0);
        check("t5_sim_ready", 32'(ready), 0);
        out_ready = 1'b0;
        tick();
        check_out("t5_sim_idle", 0, 0);
        tick();
        check_out("t5_vc1", 2, 1);
`ifdef OUT_VC_SCHED_STATS_EN
        check("t5_sent", flits_sent, 6);
        check("t5_wd_cnt2", 32'(withdraw_cnt), 1);
`endif

        // 6: async reset between edges while granting
        #3;
        reset = 1'b0;
        #1;
        check_out("t6_async", 0, 0);
        check("t6_async_ready", 32'(ready), 0);
        drive(2'b00, 0, 0, 0, 1'b0);
        tick();
        check_out("t6_held", 0, 0);
        reset = 1'b1;
        tick();
        tick();
        check("t6_ready", 32'(ready), 1);
`ifdef OUT_VC_SCHED_STATS_EN
        check("t6_sent", flits_sent, 0);
        check("t6_wd", 32'(withdraw_cnt), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
